// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite encodings for the SRAM responder:
//   - htrans_e    : HTRANS transfer types
//   - SIZE_*      : HSIZE encodings supported by the responder
//   - HRESP_*     : response encodings
//   - slv_state_e : responder data-phase FSM states (ERR1/ERR2 are only
//                   reachable when AHB_SLV_ERR_RESP_EN is defined)
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb3lite_sram_array.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_array
// MEM_DEPTH x 32-bit word store with per-byte write enables.
// Write is synchronous on the rising clock edge; read is asynchronous.
// Contents are deliberately not reset.
// Ports:
//   clk   : clock
//   we    : byte-lane write enables (bit n -> wdata[8n+7:8n])
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : combinational read data of word addr
// ---------------------------------------------------------------------------
module ahb3lite_sram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [MEM_DEPTH];

    // Byte-lane write: only enabled lanes are updated, others keep their value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
// AHB3-Lite responder backed by a word-organised on-chip SRAM.
// Accepts NONSEQ/SEQ address phases, performs byte/half/word accesses on
// natural little-endian lanes and inserts WAIT_STATES wait cycles per
// data phase.
// Optional feature macro: AHB_SLV_ERR_RESP_EN -- when defined, out-of-range,
// misaligned and oversized transfers get the two-cycle ERROR response and
// never touch the SRAM. When undefined, addresses wrap modulo MEM_DEPTH and
// misaligned low bits / oversized HSIZE are tolerated.
// Ports:
//   HCLK, HRESET          : clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST,
//   HPROT                 : address/control phase (HBURST, HPROT ignored)
//   HWDATA                : write data (data phase)
//   HREADY                : bus-level ready
//   HREADYOUT, HRESP      : slave ready / response
//   HRDATA                : read data, zero outside a read data phase
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);

    localparam int         AW       = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    // Byte-lane enables derived from size and the two low address bits.
    // Anything wider than a half-word is treated as a full word.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << a;
            SIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

`ifdef AHB_SLV_ERR_RESP_EN
    // Transfers that must be answered with ERROR instead of an SRAM access.
    function automatic logic xfer_err(input logic [HADDR_SIZE-1:0] a, input logic [2:0] size);
        logic out_of_range;
        logic mis_half;
        logic mis_word;
        logic bad_size;
        out_of_range = 64'(a) >= (64'(MEM_DEPTH) * 64'd4);
        mis_half     = (size == SIZE_HALF) && a[0];
        mis_word     = (size == SIZE_WORD) && (a[1:0] != 2'b00);
        bad_size     = size > SIZE_WORD;
        return out_of_range | mis_half | mis_word | bad_size;
    endfunction
`endif

    slv_state_e    state_q, state_d;
    slv_state_e    accept_state_s;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [3:0]    lanes_q, lanes_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;

    logic          accept_s;
    logic          err_s;
    logic [3:0]    we_s;
    logic [31:0]   mem_rdata_s;
    logic [HDATA_SIZE-1:0] hrdata_s;
    logic          unused_s;

    // HBURST/HPROT are don't-care; upper address bits only matter for error decode.
    assign unused_s = ^{HBURST, HPROT, HADDR, HSIZE};

    // Only take a new address phase while this slave is itself ready, so the
    // phase registers stay stable through wait and ERR1 cycles.
    assign accept_s = HSEL & HREADY & HTRANS[1] & hreadyout_q;

`ifdef AHB_SLV_ERR_RESP_EN
    assign err_s = xfer_err(HADDR, HSIZE);
`else
    assign err_s = 1'b0;
`endif

    // Destination state for an accepted address phase; errors beat wait states.
    always_comb begin
        accept_state_s = ST_DATA;
`ifdef AHB_SLV_ERR_RESP_EN
        if (err_s) begin
            accept_state_s = ST_ERR1;
        end else if (WAIT_CNT == 4'd0) begin
            accept_state_s = ST_DATA;
        end else begin
            accept_state_s = ST_WAIT;
        end
`else
        if (WAIT_CNT == 4'd0) begin
            accept_state_s = ST_DATA;
        end else begin
            accept_state_s = ST_WAIT;
        end
`endif
    end

    // Next-state, phase-register capture and registered ready/response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        lanes_d     = lanes_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;

        if (accept_s) begin
            idx_d   = HADDR[AW+1:2];
            write_d = HWRITE & ~err_s;
            lanes_d = err_s ? 4'b0000 : lane_mask(HSIZE, HADDR[1:0]);
        end else begin
            idx_d   = idx_q;
        end

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept_s) begin
                    state_d = accept_state_s;
                    cnt_d   = WAIT_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_WAIT;
                end
            end
`ifdef AHB_SLV_ERR_RESP_EN
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                if (accept_s) begin
                    state_d = accept_state_s;
                    cnt_d   = WAIT_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_WAIT) || (state_d == ST_ERR1)) begin
            hreadyout_d = 1'b0;
        end else begin
            hreadyout_d = 1'b1;
        end

        if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
            hresp_d = HRESP_ERROR;
        end else begin
            hresp_d = HRESP_OKAY;
        end
    end

    // State and phase registers; reset aborts any in-flight transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= {AW{1'b0}};
            write_q     <= 1'b0;
            lanes_q     <= 4'b0000;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            lanes_q     <= lanes_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Write commit happens on the edge that closes the (always ready) DATA phase.
    always_comb begin
        if ((state_q == ST_DATA) && write_q) begin
            we_s = lanes_q;
        end else begin
            we_s = 4'b0000;
        end
    end

    // Read data is only presented during a read data phase.
    always_comb begin
        if ((state_q == ST_DATA) && !write_q) begin
            hrdata_s = mem_rdata_s;
        end else begin
            hrdata_s = {HDATA_SIZE{1'b0}};
        end
    end

    ahb3lite_sram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk   (HCLK),
        .we    (we_s),
        .addr  (idx_q),
        .wdata (HWDATA),
        .rdata (mem_rdata_s)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_s;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
// Directed bench driving two responders (WAIT_STATES=0 and WAIT_STATES=2)
// from one pipelined AHB master. Expected read data is queued when a read
// address phase is issued and compared when its data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] SZ_B     = 3'b000;
    localparam logic [2:0] SZ_H     = 3'b001;
    localparam logic [2:0] SZ_W     = 3'b010;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        hsel0 = 1'b0;
    logic        hsel2 = 1'b0;
    logic [15:0] haddr = 16'h0000;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = SZ_W;
    logic [2:0]  hburst = 3'b000;
    logic [3:0]  hprot = 4'b0011;
    logic [31:0] hwdata = 32'h0;

    logic        hreadyout0, hresp0;
    logic        hreadyout2, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        hready_bus, hresp_bus;
    logic [31:0] hrdata_bus;

    int          dp_tgt = 0;
    logic        dp_pend = 1'b0;
    logic        dp_rd = 1'b0;
    logic        dp_eresp = 1'b0;
    int          last_waits = 0;
    logic [31:0] exp_q [$];

    int          n_checks = 0;
    int          n_fail = 0;

    assign hready_bus = (dp_tgt == 2) ? hreadyout2 : hreadyout0;
    assign hresp_bus  = (dp_tgt == 2) ? hresp2     : hresp0;
    assign hrdata_bus = (dp_tgt == 2) ? hrdata2    : hrdata0;

    always #5 HCLK = ~HCLK;

    ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb3lite_sram_slave #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(hreadyout2), .HRESP(hresp2), .HRDATA(hrdata2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One address phase (held until the bus is ready); completes and checks
    // the previous data phase on the way. Called and returns at a negedge.
    task automatic xfer(input int tgt, input logic [1:0] tr, input logic [15:0] a,
                        input logic w, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [31:0] rexp, input logic eresp);
        int waits;
        logic [31:0] e;
        hsel0  = (tgt == 0);
        hsel2  = (tgt == 2);
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        waits  = 0;
        while ((hready_bus !== 1'b1) && (waits < 20)) begin
            if (dp_pend) check("resp_in_wait", {31'd0, hresp_bus}, {31'd0, dp_eresp});
            @(posedge HCLK);
            @(negedge HCLK);
            waits++;
        end
        n_checks++;
        assert (waits < 20) else begin
            n_fail++;
            $error("FAIL ready_timeout: observed %0d wait cycles required fewer than 20", waits);
        end
        last_waits = waits;
        if (dp_pend) begin
            check("resp_done", {31'd0, hresp_bus}, {31'd0, dp_eresp});
            if (dp_rd) begin
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_empty: observed 0 entries required at least 1");
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                check("rdata", hrdata_bus, e);
            end else begin
                check("rdata_on_write", hrdata_bus, 32'h0);
            end
        end
        if (tr[1]) begin
            dp_pend  = 1'b1;
            dp_rd    = !w;
            dp_eresp = eresp;
            if (!w) exp_q.push_back(rexp);
        end else begin
            dp_pend = 1'b0;
        end
        @(posedge HCLK);
        dp_tgt = tgt;
        @(negedge HCLK);
        hwdata = wd;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge HCLK);
        check("rst_ready0", {31'd0, hreadyout0}, 32'd1);
        check("rst_resp0",  {31'd0, hresp0},     32'd0);
        check("rst_rdata0", hrdata0,             32'h0);
        check("rst_ready2", {31'd0, hreadyout2}, 32'd1);
        check("rst_resp2",  {31'd0, hresp2},     32'd0);
        check("rst_rdata2", hrdata2,             32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Zero-wait word write then read of address 0
        xfer(0, T_NONSEQ, 16'h0000, 1'b1, SZ_W, 32'hA5A5_A5A5, 32'h0, 1'b0);
        xfer(0, T_NONSEQ, 16'h0000, 1'b0, SZ_W, 32'h0, 32'hA5A5_A5A5, 1'b0);
        xfer(0, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        check("ws0_latency", 32'(last_waits), 32'd0);

        // Byte and half writes into an all-ones word
        xfer(0, T_NONSEQ, 16'h0004, 1'b1, SZ_W, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xfer(0, T_NONSEQ, 16'h0005, 1'b1, SZ_B, 32'hAAAA_12AA, 32'h0, 1'b0);
        xfer(0, T_SEQ,    16'h0004, 1'b0, SZ_W, 32'h0, 32'hFFFF_12FF, 1'b0);
        xfer(0, T_NONSEQ, 16'h0006, 1'b1, SZ_H, 32'hBEEF_5555, 32'h0, 1'b0);
        xfer(0, T_NONSEQ, 16'h0004, 1'b0, SZ_W, 32'h0, 32'hBEEF_12FF, 1'b0);
        xfer(0, T_NONSEQ, 16'h0004, 1'b1, SZ_H, 32'h7777_3344, 32'h0, 1'b0);
        xfer(0, T_NONSEQ, 16'h0004, 1'b0, SZ_W, 32'h0, 32'hBEEF_3344, 1'b0);
        xfer(0, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);

        // Back-to-back write then read of the same word, no idle in between
        xfer(0, T_NONSEQ, 16'h0010, 1'b1, SZ_W, 32'h1234_5678, 32'h0, 1'b0);
        xfer(0, T_NONSEQ, 16'h0010, 1'b0, SZ_W, 32'h0, 32'h1234_5678, 1'b0);
        xfer(0, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);

        // Two wait states: address phase held off while HREADY is low
        xfer(2, T_NONSEQ, 16'h0008, 1'b1, SZ_W, 32'hCAFE_F00D, 32'h0, 1'b0);
        xfer(2, T_NONSEQ, 16'h0008, 1'b0, SZ_W, 32'h0, 32'hCAFE_F00D, 1'b0);
        check("ws2_write_waits", 32'(last_waits), 32'd2);
        xfer(2, T_NONSEQ, 16'h0010, 1'b1, SZ_W, 32'h0BAD_CAFE, 32'h0, 1'b0);
        check("ws2_read_waits", 32'(last_waits), 32'd2);
        xfer(2, T_NONSEQ, 16'h0010, 1'b0, SZ_W, 32'h0, 32'h0BAD_CAFE, 1'b0);
        xfer(2, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        check("ws2_b2b_waits", 32'(last_waits), 32'd2);

        // Reset during the wait states of a write to word 3
        xfer(2, T_NONSEQ, 16'h000C, 1'b1, SZ_W, 32'h1111_2222, 32'h0, 1'b0);
        xfer(2, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        xfer(2, T_NONSEQ, 16'h000C, 1'b1, SZ_W, 32'hDEAD_BEEF, 32'h0, 1'b0);
        hsel2  = 1'b0;
        htrans = T_IDLE;
        check("pre_rst_in_wait", {31'd0, hreadyout2}, 32'd0);
        HRESET = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, hreadyout2}, 32'd1);
        check("mid_rst_resp",  {31'd0, hresp2},     32'd0);
        check("mid_rst_rdata", hrdata2,             32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET  = 1'b0;
        dp_pend = 1'b0;
        @(negedge HCLK);
        xfer(2, T_NONSEQ, 16'h000C, 1'b0, SZ_W, 32'h0, 32'h1111_2222, 1'b0);
        xfer(2, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);

`ifdef AHB_SLV_ERR_RESP_EN
        // Misaligned and out-of-range accesses get ERR1 then ERR2, SRAM untouched
        xfer(0, T_NONSEQ, 16'h0002, 1'b0, SZ_W, 32'h0, 32'h0, 1'b1);
        xfer(0, T_NONSEQ, 16'h0400, 1'b0, SZ_W, 32'h0, 32'h0, 1'b1);
        check("err1_waits_a", 32'(last_waits), 32'd1);
        xfer(0, T_NONSEQ, 16'h0400, 1'b1, SZ_W, 32'h0BAD_F00D, 32'h0, 1'b1);
        check("err1_waits_b", 32'(last_waits), 32'd1);
        xfer(0, T_NONSEQ, 16'h0000, 1'b0, SZ_W, 32'h0, 32'hA5A5_A5A5, 1'b0);
        check("err1_waits_c", 32'(last_waits), 32'd1);
        xfer(0, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        check("err_recover_waits", 32'(last_waits), 32'd0);
`else
        // Out-of-range address wraps to word 0; misaligned word ignores low bits
        xfer(0, T_NONSEQ, 16'h0400, 1'b1, SZ_W, 32'h5A5A_0001, 32'h0, 1'b0);
        xfer(0, T_NONSEQ, 16'h0000, 1'b0, SZ_W, 32'h0, 32'h5A5A_0001, 1'b0);
        xfer(0, T_NONSEQ, 16'h0002, 1'b0, SZ_W, 32'h0, 32'h5A5A_0001, 1'b0);
        xfer(0, T_IDLE,   16'h0000, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        check("alias_waits", 32'(last_waits), 32'd0);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
- AHB3-Lite responder with an on-chip word-organised SRAM. It is the slave end of the ahb3lite_if bus that our master-side bench drives.
- Decodes address and control phases, applies byte-lane writes per HSIZE, returns read data, and inserts programmable wait states.
- Sits behind the interconnect HSEL decode as the default memory target for unit and SoC sims.

Parameters:
- HADDR_SIZE, 16, address bus width (byte addresses).
- HDATA_SIZE, 32, data bus width; only 32 is supported.
- MEM_DEPTH, 256, number of HDATA_SIZE-bit words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every data phase of a valid NONSEQ/SEQ transfer (0..15).

Ports:
- HCLK in 1: bus clock; all logic on rising edge.
- HRESET in 1: asynchronous, active-high reset.
- HSEL in 1: slave select from decoder.
- HADDR in HADDR_SIZE: byte address (address phase).
- HTRANS in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE in 1: 1=write.
- HSIZE in 3: 000 byte, 001 half, 010 word.
- HBURST in 3: accepted but ignored; each beat is decoded by its own address.
- HPROT in 4: ignored.
- HWDATA in HDATA_SIZE: write data (data phase).
- HREADY in 1: bus-level ready (mux output).
- HREADYOUT out 1: slave ready.
- HRESP out 1: 0=OKAY, 1=ERROR.
- HRDATA out HDATA_SIZE: read data (data phase).

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, all phase registers cleared. SRAM contents are not reset. Reset asserted mid-transfer aborts the transfer with no write commit.
- Transfer accept: an address phase is accepted when HSEL & HREADY & HTRANS[1] on a rising edge. On accept, register addr, write, size, and the byte-lane mask.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no access. The next cycle gives a zero-wait OKAY.
- Word index = addr[log2(MEM_DEPTH)+1:2].
- Lane mask by size:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 lanes.
- Data placement is little-endian on natural lanes: byte n lives in HWDATA[8n+7:8n].
- FSM states:
  - IDLE: no pending data phase.
  - WAIT: counter loads WAIT_STATES; HREADYOUT=0 while counter != 0; decrements each cycle.
  - DATA: HREADYOUT=1 and HRESP=0.
  - ERR1/ERR2: optional feature only.
- Transitions:
  - Accept with WAIT_STATES=0 goes to DATA.
  - Accept with WAIT_STATES>0 goes to WAIT, then DATA.
  - From DATA: a new accept in the same cycle returns to DATA/WAIT (back-to-back pipelining); otherwise go to IDLE.
- Write commit: HWDATA is written into the enabled lanes on the edge that ends the data phase (HREADYOUT=1). Disabled lanes keep their old value.
- Read: HRDATA = array[word index], combinational from the array, driven during the data phase. It is valid when HREADYOUT=1 and holds 0 outside the read data phase.
- Read-after-write to the same word, back-to-back: the read data phase follows the write commit edge, so it returns the new value with no forwarding logic needed.
- Latency: the read result is visible in the cycle after the address phase plus WAIT_STATES.
- Without the optional feature, out-of-range addresses wrap modulo MEM_DEPTH, low address bits inconsistent with HSIZE are ignored (lanes are still derived as above), and HSIZE>010 is treated as a word. HRESP is always 0.

Optional Feature:
- Macro AHB_SLV_ERR_RESP_EN.
- When defined, the following accepted transfers take the AHB two-cycle ERROR response with no SRAM access:
  - addr >= MEM_DEPTH*4;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - HSIZE>010.
- The error response is ERR1 (HREADYOUT=0, HRESP=1) followed by ERR2 (HREADYOUT=1, HRESP=1).
- The error takes precedence over WAIT_STATES.
- An accept that arrives during ERR2 is processed normally.
- When not defined, the wrap/ignore behaviour above applies and the ERR states are not built.

Decomposition:
- Package ahb3lite_pkg holds:
  - HTRANS enum (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE constants (SIZE_BYTE/HALF/WORD);
  - HRESP_OKAY/HRESP_ERROR;
  - the FSM state enum.
- Sub-module ahb3lite_sram_array: MEM_DEPTH x 32, 4-bit byte-enable synchronous write, asynchronous read.
- Lane-mask and error decode stay in the top level.

Test Plan:
- WAIT_STATES=0: write word 0x0000=0xA5A5A5A5, then read 0x0000 -> HRDATA=0xA5A5A5A5 one cycle after the address phase, HRESP=0.
- Byte write 0x12 to addr 0x0005 over an existing 0xFFFFFFFF at word 1, then word read 0x0004 -> 0xFFFF12FF.
- WAIT_STATES=2: read 0x0008 -> HREADYOUT low for exactly 2 cycles, then data, with the next address phase held off by HREADY.
- Back-to-back NONSEQ write 0x0010=0x12345678 then read 0x0010 with no idle cycle -> read returns 0x12345678.
- Reset asserted during a WAIT-state write to 0x000C -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately, and word 3 is unchanged.
- AHB_SLV_ERR_RESP_EN defined: word read at 0x0002 and at 0x0400 (MEM_DEPTH=256) -> ERR1 then ERR2 for each, and SRAM is untouched. Undefined: 0x0400 aliases word 0.
